// File: rtl/branch_seq_ctrl_pkg.sv
// Shared definitions for the branch sequencing controller: opcode, widths,
// FSM encoding and a small helper for merging per-source hazard needs.
package branch_seq_ctrl_pkg;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam int         REG_W      = 5;
   localparam int         XLEN       = 32;
   localparam int         NEED_W     = 2;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      STALL    = 2'd1,
      REDIRECT = 2'd2
   } state_t;

   function automatic logic [NEED_W-1:0] maxNeed(input logic [NEED_W-1:0] a,
                                                 input logic [NEED_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// Works out how many bubbles the ID-stage branch must wait before its
// operands can be compared: 2 behind an EX load, 1 behind an EX ALU op or MEM load.
module branch_hazard_detect
   import branch_seq_ctrl_pkg::*;
(
   input  logic [REG_W-1:0]  rs1,
   input  logic [REG_W-1:0]  rs2,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic [REG_W-1:0]  mem_rd,
   input  logic              mem_mem_read,
   output logic [NEED_W-1:0] need
);

   logic [NEED_W-1:0] needRs1;
   logic [NEED_W-1:0] needRs2;

   // x0 is hardwired to zero, so a zero source never waits on anything;
   // the EX producer is younger than MEM and always dominates when it matches.
   function automatic logic [NEED_W-1:0] srcNeed(input logic [REG_W-1:0] rs);
      logic [NEED_W-1:0] r;
      r = '0;
      if (rs != '0) begin
         if (ex_reg_write && (ex_rd == rs))
            r = ex_mem_read ? 2'd2 : 2'd1;
         else if (mem_mem_read && (mem_rd == rs))
            r = 2'd1;
      end
      return r;
   endfunction

   always_comb begin
      needRs1 = srcNeed(rs1);
      needRs2 = srcNeed(rs2);
      need    = maxNeed(needRs1, needRs2);
   end

endmodule

// File: rtl/branch_seq_ctrl.sv
// Branch sequencing controller: stalls an ID-stage branch until its operands
// are ready, then resolves it, redirecting the PC for one cycle when taken.
module branch_seq_ctrl
   import branch_seq_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             id_is_branch,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] mem_rd,
   input  logic             mem_mem_read,
   input  logic             branch_taken,
   input  logic [XLEN-1:0]  branch_target,
   output logic             stall_pc,
   output logic             stall_ifid,
   output logic             bubble_idex,
   output logic             flush_ifid,
   output logic             pc_redirect,
   output logic [XLEN-1:0]  redirect_target,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] taken_count
);

   state_t            state;
   state_t            nextState;
   logic [NEED_W-1:0] cnt;
   logic [NEED_W-1:0] cntNext;
   logic [NEED_W-1:0] need;
   logic              resolve;

   branch_hazard_detect u_hazard (
      .rs1          (id_rs1),
      .rs2          (id_rs2),
      .ex_rd        (ex_rd),
      .ex_reg_write (ex_reg_write),
      .ex_mem_read  (ex_mem_read),
      .mem_rd       (mem_rd),
      .mem_mem_read (mem_mem_read),
      .need         (need)
   );

   // Next-state and pipeline controls; everything is forced low while in reset
   // so a pending stall or redirect is dropped without reaching the pipeline.
   always_comb begin
      nextState   = state;
      cntNext     = cnt;
      resolve     = 1'b0;
      stall_pc    = 1'b0;
      stall_ifid  = 1'b0;
      bubble_idex = 1'b0;
      flush_ifid  = 1'b0;
      pc_redirect = 1'b0;
      case (state)
         RUN: begin
            if (id_is_branch) begin
               if (need != '0) begin
                  stall_pc    = 1'b1;
                  stall_ifid  = 1'b1;
                  bubble_idex = 1'b1;
                  cntNext     = need - 2'd1;
                  nextState   = (need > 2'd1) ? STALL : RUN;
               end else begin
                  resolve = 1'b1;
                  if (branch_taken)
                     nextState = REDIRECT;
               end
            end
         end
         STALL: begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
            cntNext     = (cnt != '0) ? cnt - 2'd1 : '0;
            nextState   = (cntNext == '0) ? RUN : STALL;
         end
         REDIRECT: begin
            pc_redirect = 1'b1;
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
            nextState   = RUN;
         end
         default: begin
            nextState = RUN;
            cntNext   = '0;
         end
      endcase
      if (rst) begin
         resolve     = 1'b0;
         stall_pc    = 1'b0;
         stall_ifid  = 1'b0;
         bubble_idex = 1'b0;
         flush_ifid  = 1'b0;
         pc_redirect = 1'b0;
      end
   end

   // State, stall countdown, captured target and saturating statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= RUN;
         cnt             <= '0;
         redirect_target <= '0;
         branch_count    <= '0;
         taken_count     <= '0;
      end else begin
         state <= nextState;
         cnt   <= cntNext;
         if (resolve) begin
            if (branch_count != '1)
               branch_count <= branch_count + CNT_W'(1);
            if (branch_taken) begin
               redirect_target <= branch_target;
               if (taken_count != '1)
                  taken_count <= taken_count + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: doc/branch_seq_ctrl.md
BRANCH_SEQ_CTRL -- requirements
Module: branch_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the branch statistics counters.
REQ-002 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port id_is_branch  in  1  ID-stage instruction opcode equals 7'b1100011.
REQ-005 SHALL have ports id_rs1, id_rs2  in  5 each  ID-stage source register addresses.
REQ-006 SHALL have ports ex_rd  in  5, ex_reg_write  in  1, ex_mem_read  in  1  EX-stage destination, write enable, load flag.
REQ-007 SHALL have ports mem_rd  in  5, mem_mem_read  in  1  MEM-stage destination and load flag.
REQ-008 SHALL have port branch_taken  in  1  branch decider result for the ID-stage instruction.
REQ-009 SHALL have port branch_target  in  32  computed target of the ID-stage branch.
REQ-010 SHALL have ports stall_pc, stall_ifid, bubble_idex, flush_ifid, pc_redirect  out  1 each  pipeline control.
REQ-011 SHALL have port redirect_target  out  32  PC value loaded when pc_redirect=1.
REQ-012 SHALL have ports branch_count, taken_count  out  CNT_W each  resolved and taken branch totals.

Function
REQ-013 SHALL implement FSM states RUN, STALL, REDIRECT.
REQ-014 Hazard need SHALL be computed per source (rs≠0): ex_rd match with ex_reg_write -> 2 if ex_mem_read else 1; mem_rd match with mem_mem_read -> 1; otherwise 0; need = max over both sources and stages.
REQ-015 rd or rs equal to x0 SHALL never create a hazard.
REQ-016 In RUN with id_is_branch=1 and need>0: assert stall_pc, stall_ifid, bubble_idex this cycle; load cnt=need-1; next state STALL if cnt>0, else RUN.
REQ-017 In STALL: assert stall_pc, stall_ifid, bubble_idex; decrement cnt; return to RUN when cnt reaches 0; branch_taken ignored.
REQ-018 In RUN with id_is_branch=1 and need=0 (resolution cycle): increment branch_count; if branch_taken, increment taken_count, register branch_target, next state REDIRECT; else remain RUN, no control output asserted.
REQ-019 In REDIRECT (exactly one cycle): assert pc_redirect, flush_ifid, bubble_idex; redirect_target = registered target; id_is_branch ignored (wrong-path); next state RUN.
REQ-020 Taken-branch penalty SHALL be exactly 2 cycles after resolution; not-taken penalty 0.
REQ-021 Control outputs SHALL be combinational from state and inputs; redirect_target and counters registered.
REQ-022 Counters SHALL saturate at all-ones, never wrap.
REQ-023 redirect_target SHALL hold its last value outside REDIRECT.
REQ-024 Outputs SHALL be 0 whenever id_is_branch=0 in RUN.

Reset
REQ-025 rst=1 at a clock edge SHALL force state RUN, cnt=0, redirect_target=0, branch_count=0, taken_count=0, regardless of current state.
REQ-026 While rst=1 all single-bit control outputs SHALL be 0.
REQ-027 Reset mid-STALL or mid-REDIRECT SHALL abandon the pending stall/redirect without emitting pc_redirect.

Structure
REQ-028 Shared package SHALL hold OPC_BRANCH=7'b1100011, FSM state encoding, register-address width 5, XLEN 32.
REQ-029 Hazard need computation SHALL be a combinational sub-module branch_hazard_detect (inputs rs/rd/flags, output 2-bit need).
REQ-030 Block SHALL contain no storage other than state, cnt, redirect_target and the two counters.

Verification
REQ-031 Branch rs1=5, no hazards, branch_taken=1, target 0x0000_0100 -> next cycle pc_redirect=1, flush_ifid=1, bubble_idex=1, redirect_target=0x100; following cycle RUN, taken_count=1.
REQ-032 Branch rs1=5 with ex_rd=5, ex_reg_write=1, ex_mem_read=1 -> stall signals high 2 consecutive cycles, then resolution; branch_count increments once.
REQ-033 Branch rs2=0 with ex_rd=0, ex_reg_write=1 -> no stall, immediate resolution.
REQ-034 Branch not taken, no hazard -> all controls 0, branch_count+1, taken_count unchanged.
REQ-035 rst asserted during REDIRECT -> next cycle all outputs 0, counters 0, no pc_redirect.
REQ-036 Preload near saturation (CNT_W=4), 17 taken branches -> both counters stay at 4'hF.
